e_calc: RTL and testbench

- Multi-precision fixed-point calculator for Euler's number e.
- Evaluates the Horner form e ≈ 1 + 1/1·(1 + 1/2·(1 + … (1 + 1/N)…)) with N = 2^LOG2_N.
- Uses a word-serial long divider over a WORDS×16-bit accumulator.
- Standalone compute engine: a start pulse launches it, and it reports completion with a one-cycle done pulse and a held result bus.

---
 rtl/e_calc.sv | 110 +++++++++++
 tb/tb_e_calc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/e_calc.sv
// Fixed-point Euler's number engine: Horner evaluation of sum 1/k! for k=0..N
// using a word-serial long divider over a WORDS x 16-bit accumulator.
module e_calc #(
   parameter int WORDS  = 32,
   parameter int LOG2_N = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  done,
   output logic [16*WORDS-1:0]   out_data
);

   localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_DIV    = 3'd2;
   localparam logic [2:0] S_ADD1   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [15:0]   K_INIT = 16'(1 << LOG2_N);
   localparam logic [WW-1:0] W_TOP  = WW'(WORDS - 1);

   logic [2:0]    state_reg;
   logic [15:0]   acc_reg [WORDS];
   logic [15:0]   res_reg [WORDS];
   logic [15:0]   k_reg;
   logic [15:0]   r_reg;
   logic [WW-1:0] w_reg;
   logic          done_reg;

   logic [31:0]   dividend;
   logic [31:0]   divisor;
   logic [15:0]   quo_next;
   logic [15:0]   rem_next;

   // The running remainder is always below k, so the quotient fits in one word.
   assign dividend = {r_reg, acc_reg[w_reg]};
   assign divisor  = {16'd0, k_reg};
   assign quo_next = 16'(dividend / divisor);
   assign rem_next = 16'(dividend % divisor);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         k_reg     <= 16'd0;
         r_reg     <= 16'd0;
         w_reg     <= '0;
         done_reg  <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            acc_reg[i] <= 16'd0;
            res_reg[i] <= 16'd0;
         end
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start)
                  state_reg <= S_INIT;
            end
            S_INIT: begin
               for (int i = 0; i < WORDS - 1; i++)
                  acc_reg[i] <= 16'd0;
               acc_reg[WORDS-1] <= 16'd1;
               k_reg     <= K_INIT;
               r_reg     <= 16'd0;
               w_reg     <= W_TOP;
               state_reg <= S_DIV;
            end
            S_DIV: begin
               acc_reg[w_reg] <= quo_next;
               r_reg          <= rem_next;
               if (w_reg == '0)
                  state_reg <= S_ADD1;
               else
                  w_reg <= w_reg - 1'b1;
            end
            S_ADD1: begin
               // After dividing by k>=1 the integer word is at most 1, so no carry.
               acc_reg[WORDS-1] <= acc_reg[WORDS-1] + 16'd1;
               r_reg <= 16'd0;
               w_reg <= W_TOP;
               if (k_reg == 16'd1) begin
                  state_reg <= S_FINISH;
               end else begin
                  k_reg     <= k_reg - 16'd1;
                  state_reg <= S_DIV;
               end
            end
            S_FINISH: begin
               for (int i = 0; i < WORDS; i++)
                  res_reg[i] <= acc_reg[i];
               done_reg  <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_out
         assign out_data[gi*16 +: 16] = res_reg[gi];
      end
   endgenerate

   assign done = done_reg;

endmodule

// File: tb/tb_e_calc.sv
// Directed bench for e_calc: two small configurations sharing one reset.
module tb_e_calc;

   localparam int WA = 4;
   localparam int LA = 4;
   localparam int WB = 3;
   localparam int LB = 2;
   localparam int LAT_A = 2 + (1 << LA) * (WA + 1);   // 82
   localparam int LAT_B = 2 + (1 << LB) * (WB + 1);   // 18

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_a = 1'b0;
   logic              start_b = 1'b0;
   logic              done_a;
   logic              done_b;
   logic [16*WA-1:0]  out_a;
   logic [16*WB-1:0]  out_b;

   int n_cmp = 0;
   int n_bad = 0;
   int hold_bad;
   logic [16*WA-1:0] saved_a;
   logic [16*WA-1:0] first_a;

   always #5 clk = ~clk;

   e_calc #(.WORDS(WA), .LOG2_N(LA)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a), .out_data(out_a)
   );

   e_calc #(.WORDS(WB), .LOG2_N(LB)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b), .out_data(out_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Pulse start, then count edges until done; lat = -1 if the bound expires.
   task automatic run(input bit sel, input bit noisy, input bit hold, output int lat);
      lat = -1;
      @(negedge clk);
      drive(sel, 1'b1);
      @(posedge clk);
      #1 drive(sel, 1'b0);
      for (int c = 1; c <= 2000; c++) begin
         @(posedge clk);
         #1;
         if (noisy) drive(sel, (c >= 3 && c <= 60));
         if (hold && out_a !== saved_a && !done_a) hold_bad++;
         if (sel ? done_b : done_a) begin
            lat = c;
            break;
         end
      end
      drive(sel, 1'b0);
   endtask

   task automatic check_a(input string pfx);
      logic [15:0] w0;
      w0 = out_a[0 +: 16];
      check({pfx, "_w3"}, out_a[3*16 +: 16], 16'd2);
      check({pfx, "_w2"}, out_a[2*16 +: 16], 16'hB7E1);
      check({pfx, "_w1"}, out_a[1*16 +: 16], 16'h5162);
      check({pfx, "_w0_deficit"}, (w0 <= 16'h8AED && w0 >= 16'h8AAD), 1);
   endtask

   initial begin
      int lat;
      int seen;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 if (done_a || done_b) seen++;
      end
      check("idle_done", seen, 0);
      check("idle_out_a", out_a, 0);
      check("idle_out_b", out_b, 0);

      run(1'b0, 1'b0, 1'b0, lat);
      check("a_latency", lat, LAT_A);
      check_a("a");
      first_a = out_a;
      @(posedge clk);
      #1 check("a_done_one_cycle", done_a, 1'b0);

      run(1'b1, 1'b0, 1'b0, lat);
      check("b_latency", lat, LAT_B);
      check("b_w2", out_b[2*16 +: 16], 16'd2);
      check("b_w1", out_b[1*16 +: 16], 16'hB555);
      check("b_w0", out_b[0 +: 16], 16'h5555);

      run(1'b0, 1'b1, 1'b0, lat);
      check("noisy_latency", lat, LAT_A);
      check("noisy_result", out_a, first_a);
      @(posedge clk);
      #1 check("noisy_no_restart", done_a, 1'b0);

      // Abort a run halfway with an asynchronous reset.
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (40) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_a", out_a, 0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_out_b", out_b, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 if (done_a) seen++;
      end
      check("rst_no_done", seen, 0);

      run(1'b0, 1'b0, 1'b0, lat);
      check("rerun_latency", lat, LAT_A);
      check_a("rerun");

      // Back-to-back: run() raises start in the done cycle itself.
      saved_a  = out_a;
      hold_bad = 0;
      run(1'b0, 1'b0, 1'b1, lat);
      check("b2b_latency", lat, LAT_A);
      check("b2b_hold", hold_bad, 0);
      check("b2b_identical", out_a, saved_a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
